// File: rtl/dct_mac_engine.sv
// Sequential N-point DCT-II / DCT-III engine: one signed multiplier and one
// accumulator walk the coefficient ROM row by row, one MAC per cycle.
module dct_mac_engine #(
  parameter int N         = 8,
  parameter int IN_W      = 12,
  parameter int COEFF_W   = 14,
  parameter int FRAC_BITS = 12,
  parameter int OUT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*IN_W-1:0]    in_data,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*OUT_W-1:0]   out_data,
  output logic                 sat,
  output logic                 busy
);

  localparam int LGN    = $clog2(N);
  localparam int PROD_W = IN_W + COEFF_W;
  localparam int ACC_W  = PROD_W + LGN;
  localparam logic [LGN-1:0]          LAST = LGN'(N - 1);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(64'sd1 <<< (FRAC_BITS - 1));
  localparam logic signed [ACC_W-1:0] OMAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OMIN = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

  // a_k*cos(pi*(2n+1)*k/2N) built from a Q30 quarter-wave table, rounded to FRAC_BITS.
  function automatic longint coeff_f(input int k, input int n);
    int     m;
    bit     neg;
    longint c, amp, v;
    m   = ((2 * n + 1) * k * (8 / N)) % 32;
    neg = 1'b0;
    if (m > 16) m = 32 - m;
    if (m > 8) begin
      m   = 16 - m;
      neg = 1'b1;
    end
    case (m)
      0:       c = 64'sd1073741824;
      1:       c = 64'sd1053110176;
      2:       c = 64'sd992008094;
      3:       c = 64'sd892783698;
      4:       c = 64'sd759250125;
      5:       c = 64'sd596538996;
      6:       c = 64'sd410903207;
      7:       c = 64'sd209476638;
      default: c = 64'sd0;
    endcase
    if (k == 0) amp = (N == 8) ? 64'sd379625062 : 64'sd536870912;
    else        amp = (N == 8) ? 64'sd536870912 : 64'sd759250125;
    v = (c * amp + (64'sd1 <<< (59 - FRAC_BITS))) >>> (60 - FRAC_BITS);
    return neg ? -v : v;
  endfunction

  logic signed [COEFF_W-1:0] rom [N*N];
  for (genvar gk = 0; gk < N; gk++) begin : g_k
    for (genvar gn = 0; gn < N; gn++) begin : g_n
      localparam longint CV = coeff_f(gk, gn);
      assign rom[gk*N+gn] = COEFF_W'(CV);
    end
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state_q, state_d;

  logic [N-1:0][IN_W-1:0]    x_q;
  logic [N-1:0][OUT_W-1:0]   y_q;
  logic                      mode_q, out_valid_q, sat_q;
  logic [LGN-1:0]            k_q, n_q, pk_q;
  logic                      vld_q, plast_q, pfin_q;
  logic signed [PROD_W-1:0]  prod_q, xs, cs, prod;
  logic signed [ACC_W-1:0]   acc_q, acc_sum, rnd, shifted;
  logic [IN_W-1:0]           xv;
  logic signed [COEFF_W-1:0] cv;
  logic [OUT_W-1:0]          res;
  logic                      clip, accept, issue, last_in, last_all;

  assign accept   = (state_q == IDLE) && in_valid;
  assign issue    = (state_q == COMPUTE);
  assign last_in  = (n_q == LAST);
  assign last_all = last_in && (k_q == LAST);

  // Inverse mode reads the ROM transposed; N is a power of two so {row,col} is the address.
  assign xv   = x_q[n_q];
  assign cv   = mode_q ? rom[{n_q, k_q}] : rom[{k_q, n_q}];
  assign xs   = {{COEFF_W{xv[IN_W-1]}}, xv};
  assign cs   = {{IN_W{cv[COEFF_W-1]}}, cv};
  assign prod = xs * cs;

  assign acc_sum = acc_q + {{LGN{prod_q[PROD_W-1]}}, prod_q};
  assign rnd     = acc_sum + HALF;
  assign shifted = rnd >>> FRAC_BITS;

  always_comb begin
    clip = 1'b0;
    res  = shifted[OUT_W-1:0];
    if (shifted > OMAX) begin
      clip = 1'b1;
      res  = OMAX[OUT_W-1:0];
    end else if (shifted < OMIN) begin
      clip = 1'b1;
      res  = OMIN[OUT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = COMPUTE;
      COMPUTE: if (last_all) state_d = DONE;
      DONE:    if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Product register splits multiply from accumulate; the last sum retires one
  // edge after COMPUTE ends, which is when out_valid rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      k_q         <= '0;
      n_q         <= '0;
      pk_q        <= '0;
      vld_q       <= 1'b0;
      plast_q     <= 1'b0;
      pfin_q      <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= issue;
      prod_q  <= prod;
      pk_q    <= k_q;
      plast_q <= last_in;
      pfin_q  <= last_all;
      if (accept) begin
        x_q    <= in_data;
        mode_q <= mode;
        sat_q  <= 1'b0;
        k_q    <= '0;
        n_q    <= '0;
      end else if (issue) begin
        n_q <= n_q + LGN'(1);
        if (last_in) k_q <= k_q + LGN'(1);
      end
      if (vld_q) begin
        if (plast_q) begin
          y_q[pk_q] <= res;
          acc_q     <= '0;
          if (clip) sat_q <= 1'b1;
        end else begin
          acc_q <= acc_sum;
        end
        if (pfin_q) out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = y_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_dct_mac_engine.sv
// Bench for dct_mac_engine: 8-point builds at OUT_W=16 and OUT_W=12 share stimulus,
// a 4-point build runs separately; all results come from a real-arithmetic DCT model.
module tb_dct_mac_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid, mode, out_ready;
  logic [95:0]  in_data;
  logic         in_ready, out_valid, sat, busy;
  logic [127:0] out_data;
  logic         in_ready_b, out_valid_b, sat_b, busy_b;
  logic [95:0]  out_data_b;
  logic         in_valid4, mode4, out_ready4;
  logic [47:0]  in_data4;
  logic         in_ready4, out_valid4, sat4, busy4;
  logic [63:0]  out_data4;

  dct_mac_engine #(.N(8), .OUT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat(sat), .busy(busy));

  dct_mac_engine #(.N(8), .OUT_W(12)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .mode(mode), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .sat(sat_b), .busy(busy_b));

  dct_mac_engine #(.N(4), .OUT_W(16)) u_4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .mode(mode4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .sat(sat4), .busy(busy4));

  typedef struct { int y[8]; bit s; } res_t;
  res_t qa[$], qb[$], q4[$];
  int ncmp = 0, nfail = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Orthonormal DCT coefficient straight from the definition.
  function automatic int coef(input int k, input int i, input int n);
    real a, v;
    a = (k == 0) ? $sqrt(1.0 / n) : $sqrt(2.0 / n);
    v = a * $cos(3.14159265358979 * (2 * i + 1) * k / (2.0 * n)) * 4096.0;
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic res_t model(input int x[8], input bit inv, input int n, input int ow);
    res_t   r;
    longint acc, q, mx;
    mx  = (64'sd1 <<< (ow - 1)) - 1;
    r.s = 1'b0;
    for (int k = 0; k < 8; k++) r.y[k] = 0;
    for (int k = 0; k < n; k++) begin
      acc = 0;
      for (int i = 0; i < n; i++)
        acc += longint'(inv ? coef(i, k, n) : coef(k, i, n)) * x[i];
      q = (acc + 2048) >>> 12;
      if (q > mx) begin q = mx; r.s = 1'b1; end
      if (q < -mx - 1) begin q = -mx - 1; r.s = 1'b1; end
      r.y[k] = int'(q);
    end
    return r;
  endfunction

  function automatic logic [95:0] pack8(input int x[8]);
    logic [95:0] p;
    for (int k = 0; k < 8; k++) p[k*12 +: 12] = x[k][11:0];
    return p;
  endfunction

  function automatic logic [47:0] pack4(input int x[8]);
    logic [47:0] p;
    for (int k = 0; k < 4; k++) p[k*12 +: 12] = x[k][11:0];
    return p;
  endfunction

  // Single compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (qa.size() == 0) chk("spurious_valid_a", 1, 0);
        else begin
          for (int k = 0; k < 8; k++) chk("y_a", $signed(out_data[k*16 +: 16]), qa[0].y[k]);
          chk("sat_a", int'(sat), int'(qa[0].s));
          chk("in_ready_in_done", int'(in_ready), 0);
          chk("busy_in_done", int'(busy), 1);
          if (out_ready) void'(qa.pop_front());
        end
      end
      if (out_valid_b) begin
        if (qb.size() == 0) chk("spurious_valid_b", 1, 0);
        else begin
          for (int k = 0; k < 8; k++) chk("y_b", $signed(out_data_b[k*12 +: 12]), qb[0].y[k]);
          chk("sat_b", int'(sat_b), int'(qb[0].s));
          chk("busy_b", int'(busy_b & ~in_ready_b), 1);
          if (out_ready) void'(qb.pop_front());
        end
      end
      if (out_valid4) begin
        if (q4.size() == 0) chk("spurious_valid_4", 1, 0);
        else begin
          for (int k = 0; k < 4; k++) chk("y_4", $signed(out_data4[k*16 +: 16]), q4[0].y[k]);
          chk("sat_4", int'(sat4), int'(q4[0].s));
          chk("busy_4", int'(busy4 & ~in_ready4), 1);
          if (out_ready4) void'(q4.pop_front());
        end
      end
    end
  end

  task automatic expect8(input int x[8], input bit m);
    qa.push_back(model(x, m, 8, 16));
    qb.push_back(model(x, m, 8, 12));
  endtask

  task automatic send8(input int x[8], input bit m, output int ac);
    int t;
    in_data = pack8(x); mode = m; in_valid = 1'b1; t = 0;
    while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (t >= 300) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    ac = cyc; in_valid = 1'b0;
    in_data = {$urandom, $urandom, $urandom}; mode = 1'($urandom);
    expect8(x, m);
  endtask

  task automatic recv8(input int ac, input int hold, output int ya[8], output int yb[8],
                       output bit sa, output bit sb);
    int t;
    logic [127:0] cap;
    t = 0;
    while (!out_valid && t < 300) begin @(posedge clk); #1; t++; end
    if (t >= 300) chk("result_timeout", 0, 1);
    chk("latency8", cyc - ac, 65);
    cap = out_data;
    for (int k = 0; k < 8; k++) begin
      ya[k] = $signed(out_data[k*16 +: 16]);
      yb[k] = $signed(out_data_b[k*12 +: 12]);
    end
    sa = sat; sb = sat_b;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_stable", int'(out_data === cap && out_valid === 1'b1), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run4(input int x[8], input bit m, output int y[8]);
    int t, ac;
    in_data4 = pack4(x); mode4 = m; in_valid4 = 1'b1; t = 0;
    while (!in_ready4 && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) chk("accept4_timeout", 0, 1);
    @(posedge clk); #1;
    ac = cyc; in_valid4 = 1'b0; in_data4 = {$urandom, 16'($urandom)};
    q4.push_back(model(x, m, 4, 16));
    t = 0;
    while (!out_valid4 && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) chk("result4_timeout", 0, 1);
    chk("latency4", cyc - ac, 17);
    for (int k = 0; k < 8; k++) y[k] = (k < 4) ? int'($signed(out_data4[k*16 +: 16])) : 0;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int x[8], ya[8], yb[8], r[8], x2[8];
    int ac;
    bit sa, sb;
    res_t mr;
    int imp[8];
    imp = '{23, 31, 30, 27, 23, 18, 12, 6};

    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0; in_data = '0;
    in_valid4 = 1'b0; mode4 = 1'b0; out_ready4 = 1'b0; in_data4 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", int'(in_ready & in_ready_b & in_ready4), 1);
    chk("rst_out_valid", int'(out_valid | out_valid_b | out_valid4), 0);
    chk("rst_busy", int'(busy | busy_b | busy4), 0);
    chk("rst_sat", int'(sat | sat_b | sat4), 0);
    chk("rst_out_data", int'(out_data == '0 && out_data_b == '0 && out_data4 == '0), 1);

    // DC input
    for (int i = 0; i < 8; i++) x[i] = 100;
    mr = model(x, 1'b0, 8, 16);
    chk("model_dc_y0", mr.y[0], 283);
    send8(x, 1'b0, ac);
    recv8(ac, 0, ya, yb, sa, sb);
    chk("dc_y0", ya[0], 283);
    for (int k = 1; k < 8; k++) chk("dc_ac_small", int'(ya[k] >= -1 && ya[k] <= 1), 1);
    chk("dc_sat", int'(sa), 0);

    // Impulse
    for (int i = 0; i < 8; i++) x[i] = (i == 0) ? 64 : 0;
    mr = model(x, 1'b0, 8, 16);
    for (int k = 0; k < 8; k++) chk("model_impulse", mr.y[k], imp[k]);
    send8(x, 1'b0, ac);
    recv8(ac, 1, ya, yb, sa, sb);
    for (int k = 0; k < 8; k++) chk("impulse", ya[k], imp[k]);

    // Saturation on the narrow-output build, then clearing by a zero vector
    for (int i = 0; i < 8; i++) x[i] = 2047;
    send8(x, 1'b0, ac);
    recv8(ac, 2, ya, yb, sa, sb);
    chk("sat_y0_b", yb[0], 2047);
    chk("sat_flag_b", int'(sb), 1);
    chk("nosat_flag_a", int'(sa), 0);
    for (int i = 0; i < 8; i++) x[i] = 0;
    send8(x, 1'b0, ac);
    recv8(ac, 0, ya, yb, sa, sb);
    for (int k = 0; k < 8; k++) chk("zero_b", yb[k], 0);
    chk("sat_cleared_b", int'(sb), 0);

    // Backpressure with in_valid held high for the next vector
    for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(4094)) - 2047;
    for (int i = 0; i < 8; i++) x2[i] = int'($urandom_range(4094)) - 2047;
    send8(x, 1'b0, ac);
    in_data = pack8(x2); mode = 1'b1; in_valid = 1'b1;
    recv8(ac, 10, ya, yb, sa, sb);
    chk("bp_idle_after_hs", int'(busy), 0);
    chk("bp_ready_after_hs", int'(in_ready), 1);
    @(posedge clk); #1;
    ac = cyc; in_valid = 1'b0;
    expect8(x2, 1'b1);
    chk("bp_accept_busy", int'(busy), 1);
    recv8(ac, 0, ya, yb, sa, sb);

    // Full-range random vectors in both modes with random output stalls
    for (int v = 0; v < 30; v++) begin
      for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(4094)) - 2047;
      send8(x, 1'($urandom), ac);
      recv8(ac, int'($urandom_range(3)), ya, yb, sa, sb);
    end

    // Round trip: forward then inverse of the results
    for (int v = 0; v < 200; v++) begin
      for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(1400)) - 700;
      send8(x, 1'b0, ac);
      recv8(ac, int'($urandom_range(2)), ya, yb, sa, sb);
      send8(ya, 1'b1, ac);
      recv8(ac, 0, r, yb, sa, sb);
      for (int i = 0; i < 8; i++) chk("roundtrip8", int'(r[i] - x[i] <= 2 && x[i] - r[i] <= 2), 1);
    end

    // Reset during COMPUTE, then a clean transaction
    for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(4094)) - 2047;
    send8(x, 1'b0, ac);
    repeat (29) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    qa.delete(); qb.delete();
    chk("midrst_out_valid", int'(out_valid | out_valid_b), 0);
    chk("midrst_busy", int'(busy | busy_b), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    repeat (80) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(4094)) - 2047;
    send8(x, 1'b0, ac);
    recv8(ac, 0, ya, yb, sa, sb);

    // 4-point build round trip
    for (int v = 0; v < 20; v++) begin
      for (int i = 0; i < 8; i++) x[i] = (i < 4) ? int'($urandom_range(2000)) - 1000 : 0;
      run4(x, 1'b0, ya);
      run4(ya, 1'b1, r);
      for (int i = 0; i < 4; i++) chk("roundtrip4", int'(r[i] - x[i] <= 2 && x[i] - r[i] <= 2), 1);
    end

    repeat (3) @(posedge clk);
    chk("queues_drained", qa.size() + qb.size() + q4.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
